ahb_out_stage_rr: RTL and testbench
===================================

AHB_OUT_STAGE_RR -- requirements
Module: ahb_out_stage_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4; number of input ports, legal 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32; address width.
REQ-003 SHALL have parameter DATA_W, default 32; write-data width.
REQ-004 SHALL have parameter USER_W, default 32; HAUSER/HWUSER width.
REQ-005 SHALL have the following ports, as name, direction, width, meaning:
- HCLK  in  1  clock.
- HRESETn  in  1  reset.
- sel_op  in  NUM_PORTS  per-port HSEL.
- held_tran_op  in  NUM_PORTS  per-port transfer pending.
- addr_op  in  NUM_PORTS*ADDR_W  packed per-port HADDR.
- auser_op  in  NUM_PORTS*USER_W  packed per-port HAUSER.
- trans_op  in  NUM_PORTS*2  packed per-port HTRANS.
- write_op  in  NUM_PORTS  per-port HWRITE.
- size_op  in  NUM_PORTS*3  packed per-port HSIZE.
- burst_op  in  NUM_PORTS*3  packed per-port HBURST.
- prot_op  in  NUM_PORTS*4  packed per-port HPROT.
- master_op  in  NUM_PORTS*4  packed per-port HMASTER.
- mastlock_op  in  NUM_PORTS  per-port HMASTLOCK.
- wdata_op  in  NUM_PORTS*DATA_W  packed per-port HWDATA.
- wuser_op  in  NUM_PORTS*USER_W  packed per-port HWUSER.
- HREADYOUTM  in  1  slave ready.
- active_op  out  NUM_PORTS  one-hot address-phase owner.
- HSELM  out  1  slave select.
- HADDRM  out  ADDR_W  address.
- HAUSERM  out  USER_W  user address.
- HTRANSM  out  2  transfer type.
- HWRITEM  out  1  direction.
- HSIZEM  out  3  size.
- HBURSTM  out  3  burst.
- HPROTM  out  4  protection.
- HMASTERM  out  4  master ID.
- HMASTLOCKM  out  1  lock.
- HREADYMUXM  out  1  transfer done.
- HWDATAM  out  DATA_W  write data.
- HWUSERM  out  USER_W  user write data.
REQ-006 Reset HRESETn, asynchronous, active-low; clock HCLK.

Function
REQ-007 req[i] SHALL equal sel_op[i] & held_tran_op[i].
REQ-008 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_PORTS; the first requesting port wins.
REQ-009 Re-arbitration SHALL occur only when HREADYMUXM=1 and the owner is not held (REQ-010..012); otherwise addr_port SHALL be unchanged.
REQ-010 Burst hold: on an accepted NONSEQ with HBURST INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16, beat_cnt SHALL load 3, 7 or 15 respectively; on each accepted SEQ it SHALL decrement. The owner SHALL be held while beat_cnt≠0 and the owner drives SEQ or BUSY.
REQ-011 Early burst termination SHALL release the hold: owner IDLE/NONSEQ, or sel deasserted, clears beat_cnt.
REQ-012 Lock hold: hsel_lock SHALL set on accepted (HSELM & HTRANSM[1] & HMASTLOCKM) and clear when HMASTLOCKM=0 at HREADYMUXM=1. The owner SHALL be held while HMASTLOCKM & (hsel_lock | HSELM).
REQ-013 If no port requests and the owner is not held, no_port SHALL be 1: address/control outputs are 0, HTRANSM=IDLE, and active_op=0.
REQ-014 If no_port=0, address/control outputs SHALL mux combinationally from addr_port (zero-cycle latency), and active_op SHALL be one-hot at addr_port.
REQ-015 last_grant SHALL update to addr_port only on a new grant that is not held.
REQ-016 data_port SHALL register addr_port when HREADYMUXM=1; HWDATAM/HWUSERM SHALL mux from data_port.
REQ-017 slave_sel SHALL register HSELM when HREADYMUXM=1; HREADYMUXM SHALL equal slave_sel ? HREADYOUTM : 1.
REQ-018 Simultaneous release of the hold and new requests SHALL arbitrate in the same cycle with no idle insertion.

Reset
REQ-019 Reset SHALL clear addr_port, data_port, last_grant to NUM_PORTS-1 (port 0 first), beat_cnt=0, hsel_lock=0, slave_sel=0; HREADYMUXM=1 and all outputs 0.
REQ-020 Reset assertion mid-burst or mid-lock SHALL abandon the hold immediately.

Structure
REQ-021 HTRANS/HBURST encodings and the burst-length decode SHALL reside in the shared package ahb_mtx_pkg.
REQ-022 Arbitration and hold logic SHALL be the sub-module ahb_rr_arb; muxing, data-phase registers and ready logic SHALL stay in the top.

Verification
REQ-023 Ports 0..3 request single NONSEQ continuously -> grants 0,1,2,3,0 on consecutive ready cycles.
REQ-024 Port 1 issues INCR4 while port 2 requests -> port 1 is owner for 4 beats, port 2 is granted on the cycle after the 4th beat.
REQ-025 Port 0 issues a locked sequence with HSEL dropped for 2 cycles mid-lock -> port 3 is never granted until HMASTLOCK falls.
REQ-026 HREADYOUTM=0 for 3 cycles during port 2 write -> HWDATAM is held from wdata_op[2] and data_port is unchanged.
REQ-027 HRESETn pulsed mid-INCR8 -> outputs 0, HREADYMUXM=1; the first post-reset grant is port 0.

Source files
------------

// File: rtl/ahb_mtx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_mtx_pkg : shared AHB encodings and burst-length decode for the matrix
// Revision 1.0
// ---------------------------------------------------------------------------
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  localparam int BEAT_W = 4;

  // Beats remaining after the NONSEQ; undefined-length bursts never hold.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] burst);
    case (hburst_t'(burst))
      HB_WRAP4,  HB_INCR4:  burst_beats = 4'd3;
      HB_WRAP8,  HB_INCR8:  burst_beats = 4'd7;
      HB_WRAP16, HB_INCR16: burst_beats = 4'd15;
      default:              burst_beats = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_rr_arb : round-robin address-phase arbiter with burst and lock hold
// Revision 1.0
// ---------------------------------------------------------------------------
module ahb_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   sel,
  input  logic [NUM_PORTS-1:0]   mastlock,
  input  logic [NUM_PORTS*2-1:0] trans,
  input  logic                   ready,
  input  logic                   acc_sel,
  input  logic [1:0]             acc_trans,
  input  logic [2:0]             acc_burst,
  input  logic                   acc_mastlock,
  output logic [PW-1:0]          addr_port,
  output logic                   no_port
);
  import ahb_mtx_pkg::*;

  logic [PW-1:0]     r_addr_port;
  logic [PW-1:0]     r_last_grant;
  logic              r_no_port;
  logic              r_hsel_lock;
  logic              r_run;
  logic [BEAT_W-1:0] r_beat_cnt;

  logic [PW-1:0]     w_winner;
  logic              w_any;
  logic              w_burst_hold;
  logic              w_lock_hold;
  logic              w_held;
  logic              w_rearb;
  logic [1:0]        w_own_trans;
  logic [1:0]        w_trans_a [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_trans
    assign w_trans_a[p] = trans[p*2 +: 2];
  end

  always_comb begin : search
    int c;
    c        = 0;
    w_any    = 1'b0;
    w_winner = r_last_grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      c = (int'(r_last_grant) + k) % NUM_PORTS;
      if (!w_any && req[PW'(c)]) begin
        w_any    = 1'b1;
        w_winner = PW'(c);
      end
    end
  end

  // Hold decisions look at the registered owner's raw inputs, which avoids a
  // loop through the combinational output mux.
  assign w_own_trans  = w_trans_a[r_addr_port];
  assign w_burst_hold = (r_beat_cnt != '0) && sel[r_addr_port] &&
                        ((w_own_trans == HT_SEQ) || (w_own_trans == HT_BUSY));
  assign w_lock_hold  = mastlock[r_addr_port] && (r_hsel_lock || sel[r_addr_port]);
  assign w_held       = !r_no_port && (w_burst_hold || w_lock_hold);
  assign w_rearb      = r_run && ready && !w_held;

  assign addr_port = (w_rearb && w_any) ? w_winner : r_addr_port;
  assign no_port   = w_rearb ? !w_any : r_no_port;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_port  <= '0;
      r_last_grant <= PW'(NUM_PORTS - 1);
      r_no_port    <= 1'b1;
      r_hsel_lock  <= 1'b0;
      r_beat_cnt   <= '0;
      r_run        <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_addr_port <= addr_port;
      r_no_port   <= no_port;
      if (w_rearb && w_any)
        r_last_grant <= w_winner;
      if (ready) begin
        if (!acc_sel || (acc_trans == HT_IDLE))
          r_beat_cnt <= '0;
        else if (acc_trans == HT_NONSEQ)
          r_beat_cnt <= burst_beats(acc_burst);
        else if ((acc_trans == HT_SEQ) && (r_beat_cnt != '0))
          r_beat_cnt <= r_beat_cnt - 1'b1;

        if (acc_sel && acc_trans[1] && acc_mastlock)
          r_hsel_lock <= 1'b1;
        else if (!acc_mastlock)
          r_hsel_lock <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_out_stage_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_out_stage_rr : AHB matrix output stage, round-robin port selection
// Revision 1.0
// ---------------------------------------------------------------------------
module ahb_out_stage_rr #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [NUM_PORTS-1:0]        sel_op,
  input  logic [NUM_PORTS-1:0]        held_tran_op,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_op,
  input  logic [NUM_PORTS*USER_W-1:0] auser_op,
  input  logic [NUM_PORTS*2-1:0]      trans_op,
  input  logic [NUM_PORTS-1:0]        write_op,
  input  logic [NUM_PORTS*3-1:0]      size_op,
  input  logic [NUM_PORTS*3-1:0]      burst_op,
  input  logic [NUM_PORTS*4-1:0]      prot_op,
  input  logic [NUM_PORTS*4-1:0]      master_op,
  input  logic [NUM_PORTS-1:0]        mastlock_op,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_op,
  input  logic [NUM_PORTS*USER_W-1:0] wuser_op,
  input  logic                        HREADYOUTM,
  output logic [NUM_PORTS-1:0]        active_op,
  output logic                        HSELM,
  output logic [ADDR_W-1:0]           HADDRM,
  output logic [USER_W-1:0]           HAUSERM,
  output logic [1:0]                  HTRANSM,
  output logic                        HWRITEM,
  output logic [2:0]                  HSIZEM,
  output logic [2:0]                  HBURSTM,
  output logic [3:0]                  HPROTM,
  output logic [3:0]                  HMASTERM,
  output logic                        HMASTLOCKM,
  output logic                        HREADYMUXM,
  output logic [DATA_W-1:0]           HWDATAM,
  output logic [USER_W-1:0]           HWUSERM
);
  import ahb_mtx_pkg::*;

  localparam int PW = $clog2(NUM_PORTS);

  logic [ADDR_W-1:0] w_addr_a  [NUM_PORTS];
  logic [USER_W-1:0] w_auser_a [NUM_PORTS];
  logic [1:0]        w_trans_a [NUM_PORTS];
  logic [2:0]        w_size_a  [NUM_PORTS];
  logic [2:0]        w_burst_a [NUM_PORTS];
  logic [3:0]        w_prot_a  [NUM_PORTS];
  logic [3:0]        w_mast_a  [NUM_PORTS];
  logic [DATA_W-1:0] w_wdata_a [NUM_PORTS];
  logic [USER_W-1:0] w_wuser_a [NUM_PORTS];

  logic [PW-1:0]     addr_port;
  logic              no_port;
  logic [PW-1:0]     r_data_port;
  logic              r_data_valid;
  logic              r_slave_sel;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign w_addr_a[p]  = addr_op[p*ADDR_W +: ADDR_W];
    assign w_auser_a[p] = auser_op[p*USER_W +: USER_W];
    assign w_trans_a[p] = trans_op[p*2 +: 2];
    assign w_size_a[p]  = size_op[p*3 +: 3];
    assign w_burst_a[p] = burst_op[p*3 +: 3];
    assign w_prot_a[p]  = prot_op[p*4 +: 4];
    assign w_mast_a[p]  = master_op[p*4 +: 4];
    assign w_wdata_a[p] = wdata_op[p*DATA_W +: DATA_W];
    assign w_wuser_a[p] = wuser_op[p*USER_W +: USER_W];
  end

  ahb_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_arb (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req          (sel_op & held_tran_op),
    .sel          (sel_op),
    .mastlock     (mastlock_op),
    .trans        (trans_op),
    .ready        (HREADYMUXM),
    .acc_sel      (HSELM),
    .acc_trans    (HTRANSM),
    .acc_burst    (HBURSTM),
    .acc_mastlock (HMASTLOCKM),
    .addr_port    (addr_port),
    .no_port      (no_port)
  );

  always_comb begin
    active_op  = '0;
    HSELM      = 1'b0;
    HADDRM     = '0;
    HAUSERM    = '0;
    HTRANSM    = HT_IDLE;
    HWRITEM    = 1'b0;
    HSIZEM     = '0;
    HBURSTM    = '0;
    HPROTM     = '0;
    HMASTERM   = '0;
    HMASTLOCKM = 1'b0;
    if (!no_port) begin
      active_op[addr_port] = 1'b1;
      HSELM      = sel_op[addr_port];
      HADDRM     = w_addr_a[addr_port];
      HAUSERM    = w_auser_a[addr_port];
      HTRANSM    = w_trans_a[addr_port];
      HWRITEM    = write_op[addr_port];
      HSIZEM     = w_size_a[addr_port];
      HBURSTM    = w_burst_a[addr_port];
      HPROTM     = w_prot_a[addr_port];
      HMASTERM   = w_mast_a[addr_port];
      HMASTLOCKM = mastlock_op[addr_port];
    end
  end

  assign HREADYMUXM = r_slave_sel ? HREADYOUTM : 1'b1;

  // Data phase follows the address phase accepted on the last ready cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_data_port  <= '0;
      r_data_valid <= 1'b0;
      r_slave_sel  <= 1'b0;
    end else if (HREADYMUXM) begin
      r_data_port  <= addr_port;
      r_data_valid <= !no_port;
      r_slave_sel  <= HSELM;
    end
  end

  assign HWDATAM = r_data_valid ? w_wdata_a[r_data_port] : '0;
  assign HWUSERM = r_data_valid ? w_wuser_a[r_data_port] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_out_stage_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ahb_out_stage_rr : directed self-checking bench for ahb_out_stage_rr
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ahb_out_stage_rr;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int UW = 32;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [NP-1:0]    sel_op, held_tran_op, write_op, mastlock_op;
  logic [NP*AW-1:0] addr_op;
  logic [NP*UW-1:0] auser_op, wuser_op;
  logic [NP*2-1:0]  trans_op;
  logic [NP*3-1:0]  size_op, burst_op;
  logic [NP*4-1:0]  prot_op, master_op;
  logic [NP*DW-1:0] wdata_op;
  logic             HREADYOUTM;
  logic [NP-1:0]    active_op;
  logic             HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [AW-1:0]    HADDRM;
  logic [UW-1:0]    HAUSERM, HWUSERM;
  logic [1:0]       HTRANSM;
  logic [2:0]       HSIZEM, HBURSTM;
  logic [3:0]       HPROTM, HMASTERM;
  logic [DW-1:0]    HWDATAM;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_out_stage_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .USER_W(UW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel_op), .held_tran_op(held_tran_op),
    .addr_op(addr_op), .auser_op(auser_op), .trans_op(trans_op), .write_op(write_op),
    .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
    .mastlock_op(mastlock_op), .wdata_op(wdata_op), .wuser_op(wuser_op),
    .HREADYOUTM(HREADYOUTM), .active_op(active_op), .HSELM(HSELM), .HADDRM(HADDRM),
    .HAUSERM(HAUSERM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM), .HMASTLOCKM(HMASTLOCKM),
    .HREADYMUXM(HREADYMUXM), .HWDATAM(HWDATAM), .HWUSERM(HWUSERM)
  );

  function automatic logic [AW-1:0] addr_of(input int p);
    addr_of = 32'h1000_0000 + 32'(p) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p);
    wdata_of = 32'hD000_0000 + 32'(p);
  endfunction

  task automatic drive(input int p, input logic s, input logic ht, input logic [1:0] t,
                       input logic [2:0] b, input logic lk, input logic w);
    sel_op[p]            = s;
    held_tran_op[p]      = ht;
    trans_op[p*2 +: 2]   = t;
    burst_op[p*3 +: 3]   = b;
    mastlock_op[p]       = lk;
    write_op[p]          = w;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Leaves the bench one clock after reset release, ready for cycle 0.
  task automatic do_reset();
    HRESETn    = 1'b0;
    HREADYOUTM = 1'b1;
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, T_NONSEQ, B_INCR4, 1'b1, 1'b1);
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if (active_op !== 4'b0000) begin
      errors++; $display("FAIL reset_active: got %b want %b", active_op, 4'b0000);
    end
    checks++;
    if ({HSELM, HTRANSM, HWRITEM, HMASTLOCKM, HBURSTM} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %h want 00", {HSELM, HTRANSM, HWRITEM, HMASTLOCKM, HBURSTM});
    end
    checks++;
    if (HADDRM !== 32'h0 || HWDATAM !== 32'h0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", HADDRM, HWDATAM);
    end
    checks++;
    if (HREADYMUXM !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", HREADYMUXM);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    do_reset();
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_oh = 4'b0001 << (i % 4);
      checks++;
      if (active_op !== exp_oh) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", i, active_op, exp_oh);
      end
      checks++;
      if (HADDRM !== addr_of(i % 4)) begin
        errors++; $display("FAIL rr_addr%0d: got %h want %h", i, HADDRM, addr_of(i % 4));
      end
      step();
    end
  endtask

  task automatic test_burst();
    do_reset();
    drive(1, 1'b1, 1'b1, T_NONSEQ, B_INCR4, 1'b0, 1'b0);
    drive(2, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b0);
    #1;
    checks++;
    if (active_op !== 4'b0010 || HTRANSM !== T_NONSEQ) begin
      errors++; $display("FAIL burst_start: got %b/%b want 0010/10", active_op, HTRANSM);
    end
    step();
    drive(1, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0, 1'b0);
    for (int b = 1; b < 4; b++) begin
      #1;
      checks++;
      if (active_op !== 4'b0010) begin
        errors++; $display("FAIL burst_hold_beat%0d: got %b want 0010", b, active_op);
      end
      step();
    end
    drive(1, 1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    #1;
    checks++;
    if (active_op !== 4'b0100 || HADDRM !== addr_of(2)) begin
      errors++; $display("FAIL burst_next_grant: got %b/%h want 0100/%h", active_op, HADDRM, addr_of(2));
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(0, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
    drive(3, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b0);
    #1;
    checks++;
    if (active_op !== 4'b0001 || HMASTLOCKM !== 1'b1) begin
      errors++; $display("FAIL lock_start: got %b/%b want 0001/1", active_op, HMASTLOCKM);
    end
    step();
    drive(0, 1'b0, 1'b1, T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (active_op !== 4'b0001 || HSELM !== 1'b0) begin
        errors++; $display("FAIL lock_seldrop%0d: got %b/%b want 0001/0", c, active_op, HSELM);
      end
      step();
    end
    drive(0, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
    #1;
    checks++;
    if (active_op !== 4'b0001) begin
      errors++; $display("FAIL lock_resel: got %b want 0001", active_op);
    end
    step();
    drive(0, 1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    #1;
    checks++;
    if (active_op !== 4'b1000 || HMASTLOCKM !== 1'b0) begin
      errors++; $display("FAIL lock_release: got %b/%b want 1000/0", active_op, HMASTLOCKM);
    end
  endtask

  task automatic test_wait_state();
    do_reset();
    drive(2, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b1);
    #1;
    checks++;
    if (active_op !== 4'b0100 || HWRITEM !== 1'b1) begin
      errors++; $display("FAIL wait_grant: got %b/%b want 0100/1", active_op, HWRITEM);
    end
    step();
    drive(2, 1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b1);
    HREADYOUTM = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (HWDATAM !== wdata_of(2) || HREADYMUXM !== 1'b0 || active_op !== 4'b0100) begin
        errors++; $display("FAIL wait_hold%0d: got %h/%b/%b want %h/0/0100",
                           c, HWDATAM, HREADYMUXM, active_op, wdata_of(2));
      end
      step();
    end
    HREADYOUTM = 1'b1;
    #1;
    checks++;
    if (HWDATAM !== wdata_of(2) || HREADYMUXM !== 1'b1 || active_op !== 4'b0001) begin
      errors++; $display("FAIL wait_done: got %h/%b/%b want %h/1/0001",
                         HWDATAM, HREADYMUXM, active_op, wdata_of(2));
    end
    step();
    #1;
    checks++;
    if (HWDATAM !== wdata_of(0)) begin
      errors++; $display("FAIL wait_next_data: got %h want %h", HWDATAM, wdata_of(0));
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(1, 1'b1, 1'b1, T_NONSEQ, B_INCR8, 1'b0, 1'b0);
    #1;
    step();
    drive(1, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b0);
    step();
    #1;
    checks++;
    if (active_op !== 4'b0010) begin
      errors++; $display("FAIL mid_burst_owner: got %b want 0010", active_op);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (active_op !== 4'b0000 || HSELM !== 1'b0 || HTRANSM !== T_IDLE || HADDRM !== 32'h0) begin
      errors++; $display("FAIL mid_burst_reset_out: got %b/%b/%b/%h want 0000/0/00/0",
                         active_op, HSELM, HTRANSM, HADDRM);
    end
    checks++;
    if (HREADYMUXM !== 1'b1) begin
      errors++; $display("FAIL mid_burst_reset_ready: got %b want 1", HREADYMUXM);
    end
    step();
    HRESETn = 1'b1;
    step();
    #1;
    checks++;
    if (active_op !== 4'b0001) begin
      errors++; $display("FAIL post_reset_grant: got %b want 0001", active_op);
    end
  endtask

  initial begin
    HRESETn      = 1'b0;
    HREADYOUTM   = 1'b1;
    sel_op       = '0;
    held_tran_op = '0;
    write_op     = '0;
    mastlock_op  = '0;
    trans_op     = '0;
    burst_op     = '0;
    size_op      = {NP{3'd2}};
    prot_op      = {NP{4'h3}};
    master_op    = '0;
    for (int p = 0; p < NP; p++) begin
      addr_op[p*AW +: AW]   = addr_of(p);
      wdata_op[p*DW +: DW]  = wdata_of(p);
      auser_op[p*UW +: UW]  = 32'hA000_0000 + 32'(p);
      wuser_op[p*UW +: UW]  = 32'hB000_0000 + 32'(p);
      master_op[p*4 +: 4]   = 4'(p);
    end
    test_reset();
    test_round_robin();
    test_burst();
    test_lock();
    test_wait_state();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
